// File: rtl/rdout_tx_pkg.sv
//==============================================================================
// Module : rdout_tx_pkg
// Brief  : Shared defaults, frame constants and types for the readout transmitter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rdout_tx_pkg;

    localparam int           NW        = 8;
    localparam int           DW        = 32;
    localparam int           AW        = 6;
    localparam int           FRAME_LEN = NW + 2;
    localparam logic [7:0]   HDR_TAG   = 8'hA5;
    localparam int           IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/rdout_snap_reg.sv
//==============================================================================
// Module : rdout_snap_reg
// Brief  : Shadow capture of est / W_out / addr taken when a frame is triggered.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rdout_snap_reg #(
    parameter int NW = rdout_tx_pkg::NW,
    parameter int DW = rdout_tx_pkg::DW,
    parameter int AW = rdout_tx_pkg::AW
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             i_load,
    input  logic [DW-1:0]    i_est,
    input  logic [NW*DW-1:0] i_w,
    input  logic [AW-1:0]    i_addr,
    output logic [DW-1:0]    o_est,
    output logic [NW*DW-1:0] o_w,
    output logic [AW-1:0]    o_addr
);
    import rdout_tx_pkg::*;

    logic [DW-1:0]    r_est;
    logic [NW*DW-1:0] r_w;
    logic [AW-1:0]    r_addr;

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            r_est  <= '0;
            r_w    <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_est  <= i_est;
            r_w    <= i_w;
            r_addr <= i_addr;
        end
    end

    assign o_est  = r_est;
    assign o_w    = r_w;
    // Load-through view: the header is registered in the capture cycle itself.
    assign o_addr = i_load ? i_addr : r_addr;

endmodule

`default_nettype wire

// File: rtl/rdout_tx.sv
//==============================================================================
// Module : rdout_tx
// Brief  : Snapshots the readout result and streams it as one valid/ready frame.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rdout_tx #(
    parameter int         NW      = rdout_tx_pkg::NW,
    parameter int         DW      = rdout_tx_pkg::DW,
    parameter int         AW      = rdout_tx_pkg::AW,
    parameter logic [7:0] HDR_TAG = rdout_tx_pkg::HDR_TAG
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             trig,
    input  logic [DW-1:0]    est,
    input  logic [NW*DW-1:0] W_out,
    input  logic [AW-1:0]    addr,
    output logic [DW-1:0]    tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      frame_cnt
);
    import rdout_tx_pkg::*;

    localparam int C_FRAME_LEN = NW + 2;
    localparam int C_IDX_W     = $clog2(C_FRAME_LEN);
    localparam int C_PAD_W     = DW - 16 - AW;

    state_t               r_state;
    logic [C_IDX_W-1:0]   r_idx;
    logic [DW-1:0]        r_data;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_overrun;
    logic [15:0]          r_frame_cnt;

    logic [DW-1:0]        w_est_snap;
    logic [NW*DW-1:0]     w_w_snap;
    logic [AW-1:0]        w_addr_hdr;
    logic                 w_hs;
    logic                 w_final_hs;
    logic                 w_accept;
    logic [C_IDX_W-1:0]   w_nxt_idx;
    logic [DW-1:0]        w_nxt_word;
    logic [7:0]           w_hdr_seq;
    logic [DW-1:0]        w_hdr;

    assign w_hs       = r_valid & tx_ready;
    assign w_final_hs = w_hs & r_last;
    assign w_accept   = trig & ((r_state == IDLE) | w_final_hs);
    assign w_nxt_idx  = r_idx + C_IDX_W'(1);

    rdout_snap_reg #(
        .NW (NW),
        .DW (DW),
        .AW (AW)
    ) u_snap (
        .clk    (clk),
        .rst_N  (rst_N),
        .i_load (w_accept),
        .i_est  (est),
        .i_w    (W_out),
        .i_addr (addr),
        .o_est  (w_est_snap),
        .o_w    (w_w_snap),
        .o_addr (w_addr_hdr)
    );

    // A back-to-back header carries the count after the frame just closing.
    assign w_hdr_seq = (r_state == SEND) ? (r_frame_cnt[7:0] + 8'd1) : r_frame_cnt[7:0];
    assign w_hdr     = {HDR_TAG, w_hdr_seq, {C_PAD_W{1'b0}}, w_addr_hdr};

    always_comb begin
        w_nxt_word = w_est_snap;
        for (int i = 0; i < NW; i++) begin
            if (w_nxt_idx == C_IDX_W'(i + 1)) begin
                w_nxt_word = w_w_snap[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (trig && !w_accept) begin
                r_overrun <= 1'b1;
            end
            if (w_final_hs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (trig) begin
                        r_state <= SEND;
                        r_idx   <= '0;
                        r_data  <= w_hdr;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_last) begin
                            if (trig) begin
                                r_idx  <= '0;
                                r_data <= w_hdr;
                                r_last <= 1'b0;
                            end else begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx  <= w_nxt_idx;
                            r_data <= w_nxt_word;
                            r_last <= (w_nxt_idx == C_IDX_W'(C_FRAME_LEN - 1));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data   = r_data;
    assign tx_valid  = r_valid;
    assign tx_last   = r_last;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rdout_tx.sv
//==============================================================================
// Module : tb_rdout_tx
// Brief  : Self-checking bench for rdout_tx with a word-queue reference model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_rdout_tx;

    localparam int NW = 8;
    localparam int DW = 32;
    localparam int AW = 6;

    logic             clk = 1'b0;
    logic             rst_N;
    logic             trig;
    logic [DW-1:0]    est;
    logic [NW*DW-1:0] W_out;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             busy;
    logic             overrun;
    logic [15:0]      frame_cnt;

    always #5 clk = ~clk;

    rdout_tx #(
        .NW      (NW),
        .DW      (DW),
        .AW      (AW),
        .HDR_TAG (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .trig      (trig),
        .est       (est),
        .W_out     (W_out),
        .addr      (addr),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          cyc;
    } word_t;

    word_t mq[$];    // words the DUT still owes, front = currently presented
    word_t hlog[$];  // words actually handed over, with cycle stamp
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    armed  = 0;
    int    m_cnt  = 0;
    bit    m_ovr  = 0;
    bit    rand_ready = 0;
    bit    scramble   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic void push_frame();
        mq.push_back('{d: {8'hA5, 8'(m_cnt), 10'b0, addr}, last: 1'b0, cyc: 0});
        for (int i = 0; i < NW; i++)
            mq.push_back('{d: W_out[32*i +: 32], last: 1'b0, cyc: 0});
        mq.push_back('{d: est, last: 1'b1, cyc: 0});
    endfunction

    always @(posedge clk) cyc++;

    // Reference model: a frame is a list of words; a trigger is taken only
    // when nothing is left to send after this cycle's handshake.
    always @(negedge clk) begin
        bit    exp_busy;
        bit    hs;
        word_t w;
        if (!rst_N) begin
            mq.delete();
            m_cnt = 0;
            m_ovr = 0;
            armed = 1;
        end else if (armed) begin
            exp_busy = (mq.size() > 0);
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_busy});
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            if (exp_busy) begin
                chk("tx_data", tx_data, mq[0].d);
                chk("tx_last", {31'b0, tx_last}, {31'b0, mq[0].last});
            end
            chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, 16'(m_cnt)});
            hs = exp_busy && tx_ready;
            if (hs) begin
                hlog.push_back('{d: tx_data, last: tx_last, cyc: cyc});
                w = mq.pop_front();
                if (w.last) m_cnt++;
            end
            if (trig) begin
                if (mq.size() == 0) push_frame();
                else m_ovr = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        for (int i = 0; i < NW; i++) W_out[32*i +: 32] = 32'h1000_0000 + i;
        est  = 32'hDEAD_BEEF;
        addr = 6'd5;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while ((busy || tx_valid) && n < maxc) begin
            if (rand_ready) tx_ready = ($urandom_range(0, 9) < 3);
            if (scramble) begin
                est   = $urandom;
                addr  = AW'($urandom);
                for (int i = 0; i < NW; i++) W_out[32*i +: 32] = $urandom;
            end
            tick();
            n++;
        end
        chk({nm, "_timeout"}, {31'b0, (n < maxc)}, 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        rst_N    = 1'b0;
        trig     = 1'b0;
        tx_ready = 1'b0;
        est      = '0;
        W_out    = '0;
        addr     = '0;
        repeat (3) tick();
        rst_N = 1'b1;
        chk("reset_tx_data", tx_data, 32'h0);
        chk("reset_frame_cnt", {16'b0, frame_cnt}, 32'h0);

        // Basic frame
        set_basic();
        tx_ready = 1'b1;
        hlog.delete();
        pulse_trig();
        wait_idle(40, "basic");
        chk("basic_len", hlog.size(), 32'd10);
        if (hlog.size() == 10) begin
            chk("basic_hdr", hlog[0].d, 32'hA500_0005);
            chk("basic_w0", hlog[1].d, 32'h1000_0000);
            chk("basic_w7", hlog[8].d, 32'h1000_0007);
            chk("basic_est", hlog[9].d, 32'hDEAD_BEEF);
            chk("basic_last", {31'b0, hlog[9].last}, 32'd1);
        end
        chk("basic_cnt", {16'b0, frame_cnt}, 32'd1);

        // Backpressure
        hlog.delete();
        rand_ready = 1;
        pulse_trig();
        wait_idle(400, "bp");
        rand_ready = 0;
        tx_ready   = 1'b1;
        chk("bp_len", hlog.size(), 32'd10);
        if (hlog.size() == 10) begin
            chk("bp_hdr", hlog[0].d, 32'hA501_0005);
            chk("bp_w3", hlog[4].d, 32'h1000_0003);
            chk("bp_est", hlog[9].d, 32'hDEAD_BEEF);
        end

        // Input isolation
        hlog.delete();
        for (int i = 0; i < NW; i++) W_out[32*i +: 32] = 32'h2000_0000 + i;
        est  = 32'hCAFE_0001;
        addr = 6'd9;
        pulse_trig();
        scramble = 1;
        wait_idle(40, "iso");
        scramble = 0;
        if (hlog.size() == 10) begin
            chk("iso_hdr", hlog[0].d, 32'hA502_0009);
            chk("iso_w3", hlog[4].d, 32'h2000_0003);
            chk("iso_est", hlog[9].d, 32'hCAFE_0001);
        end else begin
            chk("iso_len", hlog.size(), 32'd10);
        end

        // Back-to-back
        set_basic();
        hlog.delete();
        pulse_trig();
        n = 0;
        while (!(tx_valid && tx_last) && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_reach_last", {31'b0, (n < 50)}, 32'd1);
        pulse_trig();
        wait_idle(40, "b2b");
        chk("b2b_len", hlog.size(), 32'd20);
        if (hlog.size() == 20) begin
            chk("b2b_hdr2", hlog[10].d, 32'hA504_0005);
            chk("b2b_gap", hlog[10].cyc - hlog[9].cyc, 32'd1);
        end

        // Overrun
        hlog.delete();
        pulse_trig();
        repeat (3) tick();
        pulse_trig();
        wait_idle(40, "ovr");
        repeat (3) tick();
        chk("ovr_flag", {31'b0, overrun}, 32'd1);
        chk("ovr_len", hlog.size(), 32'd10);
        chk("ovr_cnt", {16'b0, frame_cnt}, 32'd6);

        // Reset mid-frame, with trig coincident with reset
        pulse_trig();
        repeat (3) tick();
        rst_N = 1'b0;
        trig  = 1'b1;
        tick();
        chk("rst_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("rst_ovr", {31'b0, overrun}, 32'd0);
        rst_N = 1'b1;
        trig  = 1'b0;
        tick();
        chk("rst_no_snap", {31'b0, tx_valid}, 32'd0);
        hlog.delete();
        pulse_trig();
        wait_idle(40, "post_rst");
        if (hlog.size() == 10) chk("post_rst_seq", {24'b0, hlog[0].d[23:16]}, 32'd0);
        else chk("post_rst_len", hlog.size(), 32'd10);

        // Sequence byte wrap over 260 back-to-back frames
        hlog.delete();
        trig = 1'b1;
        n    = 0;
        for (int g = 0; g < 4000 && n < 260; g++) begin
            tick();
            if (tx_valid && tx_last) begin
                n++;
                if (n == 260) trig = 1'b0;
            end
        end
        trig = 1'b0;
        wait_idle(40, "wrap");
        chk("wrap_len", hlog.size(), 32'd2600);
        bad = 0;
        for (int i = 0; i < 260 && 10*i < hlog.size(); i++)
            if (hlog[10*i].d[23:16] != 8'(i + 1)) bad++;
        chk("wrap_seq_bad", bad, 32'd0);
        if (hlog.size() == 2600) chk("wrap_seq_255", {24'b0, hlog[2550].d[23:16]}, 32'd0);
        chk("wrap_cnt", {16'b0, frame_cnt}, 32'd261);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rdout_tx.md
# rdout_tx

Transmit end of the readout result path. On a trigger, snapshots the readout's current estimate `est`, the learned weight vector `W_out` and the training-data address. It then serialises them as one framed word stream over a valid/ready handshake to the host-side capture logic. Sits directly after the readout; it is the producer side of the result link whose consumer is the host capture FIFO.

## Interface
Parameters:
- NW, 8: number of 32-bit weights in `W_out`
- DW, 32: word width of `est`, weights and `tx_data`
- AW, 6: training-data address width
- HDR_TAG, 8'hA5: constant tag carried in header bits [31:24]

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_N  in  1  synchronous active-low reset, sampled on `clk`
- trig  in  1  snapshot request, single-cycle pulse or level
- est  in  DW  readout estimate
- W_out  in  NW*DW  packed weights; weight i is at [DW*i+DW-1 : DW*i]
- addr  in  AW  training-data address associated with `est`
- tx_data  out  DW  frame word
- tx_valid  out  1  `tx_data` valid
- tx_ready  in  1  consumer accepts the word this cycle
- tx_last  out  1  marks the final word of a frame; meaningful only while `tx_valid` is high
- busy  out  1  a frame is in progress
- overrun  out  1  sticky: a trigger was dropped
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF → 0

## Operation
- Frame length is FRAME_LEN = NW+2 words:
  - word 0 is the header, {HDR_TAG, frame_cnt[7:0], 10'b0, addr_snap}
  - words 1..NW are W_out weights 0..NW-1
  - word NW+1 is `est_snap`, with `tx_last` high
- Snapshot: on an accepted trigger, `est`, `W_out` and `addr` are captured into shadow registers. The frame is built only from the shadow copies, so input changes during a frame have no effect.
- FSM states:
  - IDLE: `tx_valid`=0, `busy`=0. `trig`=1 → capture snapshot, word index := 0, go to SEND.
  - SEND: `tx_valid`=1, `busy`=1. A handshake (`tx_valid`&`tx_ready`) advances the word index.
    - Handshake on a non-final word → stay in SEND.
    - Handshake on the final word → `frame_cnt`+1. Then, if `trig`=1 in that same cycle, capture a new snapshot, word index := 0 and stay in SEND (back-to-back frame). Otherwise go to IDLE.
- Trigger acceptance: accepted in IDLE, or in SEND only in the cycle the final word handshakes. In any other SEND cycle, `trig`=1 sets `overrun`, and the trigger is dropped.
- `overrun` clears only on reset.
- Handshake rules:
  - Once `tx_valid` is high, `tx_valid`, `tx_data` and `tx_last` hold stable until the handshake.
  - `tx_valid` never depends combinationally on `tx_ready`.
  - `tx_ready` may toggle freely.
- Header byte [23:16] carries `frame_cnt[7:0]` as it was before the increment for this frame, so the first frame after reset has sequence 0.

## Timing
- All outputs are registered.
- Reset values: `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `overrun`=0, `frame_cnt`=0. Shadow registers clear to 0 and the FSM goes to IDLE.
- Latency: `trig` sampled high in IDLE at edge n → header presented with `tx_valid`=1 after edge n (cycle n+1).
- With `tx_ready` held high: one word per cycle, frame = FRAME_LEN cycles. Back-to-back frames have zero idle cycles between `tx_last` and the next header.
- `frame_cnt` updates on the edge of the final-word handshake. `busy` falls on that same edge unless a back-to-back trigger was accepted.
- Reset mid-frame: `rst_N` low at edge k → `tx_valid`=0 after edge k. The partial frame is abandoned with no `tx_last`, and all counters clear.
- Simultaneous reset and `trig`: reset wins, so no snapshot is taken.

## Structure
- Package `rdout_tx_pkg` holds:
  - NW, DW, AW defaults
  - FRAME_LEN
  - HDR_TAG
  - the state enum {IDLE, SEND}
  - the word-index type (width clog2(FRAME_LEN))
- One sub-module, `rdout_snap_reg`: the shadow capture register for `est`/`W_out`/`addr`, with a load enable and synchronous clear. The top level holds the FSM, the index counter, the output mux, `frame_cnt` and `overrun`.

## Test plan
- Basic frame:
  - Stimulus: reset; `W_out` weight i = 32'h1000_0000+i; `est`=32'hDEAD_BEEF; `addr`=6'd5; `trig` pulse; `tx_ready`=1.
  - Required: 10 words — header 32'hA500_0005, then 32'h1000_0000…32'h1000_0007, then 32'hDEAD_BEEF with `tx_last`. `frame_cnt`=1 afterwards.
- Backpressure:
  - Stimulus: same frame with `tx_ready` random at 30% duty.
  - Required: identical word sequence, and `tx_data`/`tx_valid` stable during every stall.
- Input isolation:
  - Stimulus: change `est`/`W_out`/`addr` every cycle during a frame.
  - Required: the frame still carries the values sampled at the trigger.
- Back-to-back and overrun:
  - Stimulus: `trig` high in the final-handshake cycle.
  - Required: the next header follows with no gap and sequence byte 8'h01.
  - Stimulus: `trig` pulse at word 3.
  - Required: `overrun`=1, no extra frame emitted.
- Reset mid-frame:
  - Stimulus: `rst_N` low at word 4.
  - Required: `tx_valid`=0 the next cycle; `frame_cnt`=0, `overrun`=0. The next triggered frame's header shows sequence 0.
- Counter wrap:
  - Stimulus: run 65536 frames.
  - Required: `frame_cnt` wraps to 0, and header sequence bytes cycle 00…FF.
